// File: rtl/ram_arbiter_if.sv
// Bundle between two requesters, the shared bus/RAM and the arbiter.
// The arbiter uses the slave view; whoever drives requests uses the master view.
interface ram_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [1:0]            i_REQ;
  logic [1:0]            i_WE;
  logic [ADDR_WIDTH-1:0] i_ADDR0;
  logic [ADDR_WIDTH-1:0] i_ADDR1;
  logic [DATA_WIDTH-1:0] i_WDATA0;
  logic [DATA_WIDTH-1:0] i_WDATA1;
  logic [DATA_WIDTH-1:0] i_BUS;

  logic [1:0]            o_GRANT;
  logic [1:0]            o_ACK;
  logic [DATA_WIDTH-1:0] o_RDATA;
  logic                  o_BUSY;
  logic [ADDR_WIDTH-1:0] o_MAR_DATA;
  logic                  o_RAM_READ_BUS;
  logic                  o_RAM_WRITE_BUS;
  logic                  o_BUS_DRIVE;
  logic [DATA_WIDTH-1:0] o_BUS_DATA;

  modport slave (
    input  i_REQ, i_WE, i_ADDR0, i_ADDR1, i_WDATA0, i_WDATA1, i_BUS,
    output o_GRANT, o_ACK, o_RDATA, o_BUSY, o_MAR_DATA,
           o_RAM_READ_BUS, o_RAM_WRITE_BUS, o_BUS_DRIVE, o_BUS_DATA
  );

  modport master (
    output i_REQ, i_WE, i_ADDR0, i_ADDR1, i_WDATA0, i_WDATA1, i_BUS,
    input  o_GRANT, o_ACK, o_RDATA, o_BUSY, o_MAR_DATA,
           o_RAM_READ_BUS, o_RAM_WRITE_BUS, o_BUS_DRIVE, o_BUS_DATA
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester RAM arbiter. Each transaction walks IDLE -> ADDR -> XFER -> DONE,
// ties alternate round-robin, and every output comes straight from a flop.
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic           i_CLOCK,
  input logic           i_RESET_N,
  ram_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state_q,       state_d;
  logic                  lastOwner_q,   lastOwner_d;
  logic                  we_q,          we_d;
  logic [DATA_WIDTH-1:0] wdata_q,       wdata_d;
  logic [1:0]            grant_q,       grant_d;
  logic [1:0]            ack_q,         ack_d;
  logic                  busy_q,        busy_d;
  logic [ADDR_WIDTH-1:0] mar_q,         mar_d;
  logic [DATA_WIDTH-1:0] rdata_q,       rdata_d;
  logic                  ramReadBus_q,  ramReadBus_d;
  logic                  ramWriteBus_q, ramWriteBus_d;
  logic                  busDrive_q,    busDrive_d;
  logic [DATA_WIDTH-1:0] busData_q,     busData_d;
  logic                  nextOwner;

  // Requester 1 wins when it asks alone, or on a tie when requester 0 went last.
  assign nextOwner = bus.i_REQ[1] && (!bus.i_REQ[0] || (lastOwner_q == 1'b0));

  // Next-state and next-output logic; strobes and ack default low so each lasts one cycle.
  always_comb begin
    state_d       = state_q;
    lastOwner_d   = lastOwner_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    grant_d       = grant_q;
    ack_d         = 2'b00;
    busy_d        = busy_q;
    mar_d         = mar_q;
    rdata_d       = rdata_q;
    ramReadBus_d  = 1'b0;
    ramWriteBus_d = 1'b0;
    busDrive_d    = 1'b0;
    busData_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (|bus.i_REQ) begin
          lastOwner_d = nextOwner;
          we_d        = bus.i_WE[nextOwner];
          mar_d       = nextOwner ? bus.i_ADDR1  : bus.i_ADDR0;
          wdata_d     = nextOwner ? bus.i_WDATA1 : bus.i_WDATA0;
          grant_d     = nextOwner ? 2'b10 : 2'b01;
          busy_d      = 1'b1;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        state_d = S_XFER;
        if (we_q) begin
          ramReadBus_d = 1'b1;
          busDrive_d   = 1'b1;
          busData_d    = wdata_q;
        end else begin
          ramWriteBus_d = 1'b1;
        end
      end
      S_XFER: begin
        state_d = S_DONE;
        ack_d   = grant_q;
        if (!we_q) begin
          rdata_d = bus.i_BUS;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything and makes requester 0 win the first tie.
  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q       <= S_IDLE;
      lastOwner_q   <= 1'b1;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      grant_q       <= 2'b00;
      ack_q         <= 2'b00;
      busy_q        <= 1'b0;
      mar_q         <= '0;
      rdata_q       <= '0;
      ramReadBus_q  <= 1'b0;
      ramWriteBus_q <= 1'b0;
      busDrive_q    <= 1'b0;
      busData_q     <= '0;
    end else begin
      state_q       <= state_d;
      lastOwner_q   <= lastOwner_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      grant_q       <= grant_d;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
      mar_q         <= mar_d;
      rdata_q       <= rdata_d;
      ramReadBus_q  <= ramReadBus_d;
      ramWriteBus_q <= ramWriteBus_d;
      busDrive_q    <= busDrive_d;
      busData_q     <= busData_d;
    end
  end

  assign bus.o_GRANT         = grant_q;
  assign bus.o_ACK           = ack_q;
  assign bus.o_RDATA         = rdata_q;
  assign bus.o_BUSY          = busy_q;
  assign bus.o_MAR_DATA      = mar_q;
  assign bus.o_RAM_READ_BUS  = ramReadBus_q;
  assign bus.o_RAM_WRITE_BUS = ramWriteBus_q;
  assign bus.o_BUS_DRIVE     = busDrive_q;
  assign bus.o_BUS_DATA      = busData_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a small RAM device sits on the bus, a transaction-level
// model predicts winners and read data, and a monitor watches bus safety every cycle.
module tb_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 8;

  typedef struct {
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic [1:0] expGrant;
    logic [7:0] expMar;
    logic [7:0] expRdata;
  } vec_t;

  logic clock   = 1'b0;
  logic resetN  = 1'b1;
  logic ramInit = 1'b1;
  logic prevXfer = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   violations = 0;
  int   cycleCount = 0;
  logic [DW-1:0] tbRam  [256];
  logic [DW-1:0] refMem [256];
  logic          refLast;
  vec_t          vectors [7];

  ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_CLOCK  (clock),
    .i_RESET_N(resetN),
    .bus      (bus)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clock = ~clock;

  // Cycle counter used only for messages
  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Resolved bus: the RAM drives on a memory read, the arbiter drives on a memory write
  assign bus.i_BUS = bus.o_RAM_WRITE_BUS ? tbRam[bus.o_MAR_DATA]
                   : (bus.o_BUS_DRIVE ? bus.o_BUS_DATA : '0);

  // RAM device: cleared and preloaded while ramInit is high, otherwise captures the bus on write strobes
  always @(posedge clock) begin
    if (ramInit) begin
      for (int i = 0; i < 256; i++) tbRam[i] <= '0;
      tbRam[8'hFF] <= 8'h3C;
    end else if (bus.o_RAM_READ_BUS) begin
      tbRam[bus.o_MAR_DATA] <= bus.i_BUS;
    end
  end

  // Protocol monitor: no contention, no double strobe, ack only in the cycle after a strobe
  always @(negedge clock) begin
    if (bus.o_BUS_DRIVE && bus.o_RAM_WRITE_BUS) begin
      violations <= violations + 1;
      $display("[TB] FAIL contention: busDrive=1 ramWriteBus=1 at cycle %0d", cycleCount);
    end
    if (bus.o_RAM_READ_BUS && bus.o_RAM_WRITE_BUS) begin
      violations <= violations + 1;
      $display("[TB] FAIL dualStrobe: ramReadBus=1 ramWriteBus=1 at cycle %0d", cycleCount);
    end
    if ((bus.o_ACK != 2'b00) && (!prevXfer || (bus.o_ACK !== bus.o_GRANT) || !bus.o_BUSY
        || bus.o_RAM_READ_BUS || bus.o_RAM_WRITE_BUS)) begin
      violations <= violations + 1;
      $display("[TB] FAIL ackOutsideDone: ack=%b grant=%b busy=%b at cycle %0d",
               bus.o_ACK, bus.o_GRANT, bus.o_BUSY, cycleCount);
    end
    prevXfer <= bus.o_RAM_READ_BUS | bus.o_RAM_WRITE_BUS;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyReset();
    resetN = 1'b0;
    tick();
    tick();
    resetN  = 1'b1;
    refLast = 1'b1;
  endtask

  // Transaction-level prediction: winner from the round-robin rule, read data from the model memory
  function automatic vec_t modelTxn(input logic [1:0] req, input logic [1:0] we,
                                    input logic [7:0] a0, input logic [7:0] a1,
                                    input logic [7:0] d0, input logic [7:0] d1);
    vec_t v;
    int   winner;
    if (req == 2'b01)      winner = 0;
    else if (req == 2'b10) winner = 1;
    else                   winner = (refLast == 1'b0) ? 1 : 0;
    v.req      = req;
    v.we       = we;
    v.addr0    = a0;
    v.addr1    = a1;
    v.wdata0   = d0;
    v.wdata1   = d1;
    v.expGrant = (winner == 1) ? 2'b10 : 2'b01;
    v.expMar   = (winner == 1) ? a1 : a0;
    v.expRdata = refMem[v.expMar];
    return v;
  endfunction

  // One complete transaction from an IDLE cycle, checking every phase at its exact cycle
  task automatic applyStimulus(input vec_t v, input string name);
    logic       isWrite;
    logic [7:0] wd;
    isWrite = v.expGrant[1] ? v.we[1] : v.we[0];
    wd      = v.expGrant[1] ? v.wdata1 : v.wdata0;
    bus.i_REQ    = v.req;
    bus.i_WE     = v.we;
    bus.i_ADDR0  = v.addr0;
    bus.i_ADDR1  = v.addr1;
    bus.i_WDATA0 = v.wdata0;
    bus.i_WDATA1 = v.wdata1;
    tick();
    checkOutput({name, " addrGrant"}, 32'(bus.o_GRANT), 32'(v.expGrant));
    checkOutput({name, " addrBusy"}, 32'(bus.o_BUSY), 32'd1);
    checkOutput({name, " addrMar"}, 32'(bus.o_MAR_DATA), 32'(v.expMar));
    checkOutput({name, " addrStrobes"},
                32'({bus.o_RAM_READ_BUS, bus.o_RAM_WRITE_BUS, bus.o_BUS_DRIVE, bus.o_ACK}), 32'd0);
    tick();
    checkOutput({name, " xferStrobes"},
                32'({bus.o_RAM_READ_BUS, bus.o_RAM_WRITE_BUS, bus.o_BUS_DRIVE}),
                isWrite ? 32'b101 : 32'b010);
    if (isWrite) checkOutput({name, " xferBusData"}, 32'(bus.o_BUS_DATA), 32'(wd));
    checkOutput({name, " xferAck"}, 32'(bus.o_ACK), 32'd0);
    tick();
    checkOutput({name, " doneAck"}, 32'(bus.o_ACK), 32'(v.expGrant));
    checkOutput({name, " doneMar"}, 32'(bus.o_MAR_DATA), 32'(v.expMar));
    checkOutput({name, " doneStrobes"},
                32'({bus.o_RAM_READ_BUS, bus.o_RAM_WRITE_BUS, bus.o_BUS_DRIVE}), 32'd0);
    if (!isWrite) checkOutput({name, " rdata"}, 32'(bus.o_RDATA), 32'(v.expRdata));
    bus.i_REQ = 2'b00;
    tick();
    checkOutput({name, " idleState"}, 32'({bus.o_GRANT, bus.o_ACK, bus.o_BUSY}), 32'd0);
    refLast = v.expGrant[1];
    if (isWrite) refMem[v.expMar] = wd;
  endtask

  initial begin
    int   waits;
    logic sawGrant;
    vec_t v;

    bus.i_REQ    = 2'b00;
    bus.i_WE     = 2'b00;
    bus.i_ADDR0  = '0;
    bus.i_ADDR1  = '0;
    bus.i_WDATA0 = '0;
    bus.i_WDATA1 = '0;
    for (int i = 0; i < 256; i++) refMem[i] = '0;
    refMem[8'hFF] = 8'h3C;
    refLast = 1'b1;

    // Asynchronous reset takes effect before any clock edge
    #1 resetN = 1'b0;
    #2;
    checkOutput("reset grant/ack/busy", 32'({bus.o_GRANT, bus.o_ACK, bus.o_BUSY}), 32'd0);
    checkOutput("reset strobes",
                32'({bus.o_RAM_READ_BUS, bus.o_RAM_WRITE_BUS, bus.o_BUS_DRIVE}), 32'd0);
    checkOutput("reset mar", 32'(bus.o_MAR_DATA), 32'd0);
    checkOutput("reset rdata", 32'(bus.o_RDATA), 32'd0);
    checkOutput("reset busData", 32'(bus.o_BUS_DATA), 32'd0);
    tick();
    tick();
    ramInit = 1'b0;
    resetN  = 1'b1;

    // Hand-derived vectors starting from reset (requester 0 wins the first tie)
    vectors[0] = '{2'b01, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00, 2'b01, 8'h10, 8'h00};
    vectors[1] = '{2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01, 8'h10, 8'hA5};
    vectors[2] = '{2'b10, 2'b10, 8'h00, 8'h20, 8'h00, 8'h5A, 2'b10, 8'h20, 8'h00};
    vectors[3] = '{2'b11, 2'b00, 8'h20, 8'h10, 8'h00, 8'h00, 2'b01, 8'h20, 8'h5A};
    vectors[4] = '{2'b11, 2'b11, 8'h30, 8'h31, 8'h11, 8'h22, 2'b10, 8'h31, 8'h00};
    vectors[5] = '{2'b11, 2'b00, 8'h31, 8'h30, 8'h00, 8'h00, 2'b01, 8'h31, 8'h22};
    vectors[6] = '{2'b10, 2'b00, 8'h00, 8'hFF, 8'h00, 8'h00, 2'b10, 8'hFF, 8'h3C};
    for (int i = 0; i < 7; i++) applyStimulus(vectors[i], $sformatf("vec%0d", i));

    // Requester 0 drops its request during ADDR: still completes, no second grant
    bus.i_REQ   = 2'b01;
    bus.i_WE    = 2'b00;
    bus.i_ADDR0 = 8'h10;
    tick();
    checkOutput("drop grant", 32'(bus.o_GRANT), 32'b01);
    bus.i_REQ = 2'b00;
    tick();
    checkOutput("drop xfer", 32'(bus.o_RAM_WRITE_BUS), 32'd1);
    tick();
    checkOutput("drop ack", 32'(bus.o_ACK), 32'b01);
    checkOutput("drop rdata", 32'(bus.o_RDATA), 32'hA5);
    sawGrant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.o_GRANT != 2'b00 || bus.o_BUSY) sawGrant = 1'b1;
    end
    checkOutput("drop noRegrant", 32'(sawGrant), 32'd0);
    refLast = 1'b0;

    // Both requests held after reset: grants alternate with an ack every 4 cycles
    applyReset();
    bus.i_REQ   = 2'b11;
    bus.i_WE    = 2'b00;
    bus.i_ADDR0 = 8'h10;
    bus.i_ADDR1 = 8'h20;
    for (int k = 0; k < 4; k++) begin
      waits = 0;
      do begin
        tick();
        waits++;
      end while (bus.o_ACK == 2'b00 && waits < 8);
      checkOutput($sformatf("rr ack%0d", k), 32'(bus.o_ACK), (k % 2 == 0) ? 32'b01 : 32'b10);
      checkOutput($sformatf("rr spacing%0d", k), 32'(waits), (k == 0) ? 32'd3 : 32'd4);
    end
    bus.i_REQ = 2'b00;
    tick();
    tick();
    checkOutput("rr idle", 32'({bus.o_GRANT, bus.o_BUSY}), 32'd0);
    refLast = 1'b1;

    // Reset during the XFER of a write aborts it: strobes drop at once, no ack, RAM untouched
    bus.i_REQ    = 2'b01;
    bus.i_WE     = 2'b01;
    bus.i_ADDR0  = 8'h40;
    bus.i_WDATA0 = 8'h77;
    tick();
    checkOutput("abort grant", 32'(bus.o_GRANT), 32'b01);
    tick();
    checkOutput("abort xfer", 32'({bus.o_RAM_READ_BUS, bus.o_BUS_DRIVE}), 32'b11);
    resetN = 1'b0;
    #1;
    checkOutput("abort outputs",
                32'({bus.o_GRANT, bus.o_ACK, bus.o_BUSY, bus.o_RAM_READ_BUS,
                     bus.o_RAM_WRITE_BUS, bus.o_BUS_DRIVE}), 32'd0);
    checkOutput("abort mar", 32'(bus.o_MAR_DATA), 32'd0);
    bus.i_REQ = 2'b00;
    tick();
    checkOutput("abort noAck", 32'(bus.o_ACK), 32'd0);
    resetN  = 1'b1;
    refLast = 1'b1;
    v = '{2'b11, 2'b00, 8'h40, 8'h10, 8'h00, 8'h00, 2'b01, 8'h40, 8'h00};
    applyStimulus(v, "postAbortTie");

    // Randomized transactions against the model
    applyReset();
    for (int i = 0; i < 40; i++) begin
      v = modelTxn(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
                   8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                   8'($urandom), 8'($urandom));
      applyStimulus(v, $sformatf("rand%0d", i));
    end

    tick();
    checkOutput("monitor violations", 32'(violations), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the bus and RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, the RAM address width (256 words).
REQ-003 i_CLOCK  input  1  single clock; all state updates on its rising edge.
REQ-004 i_RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 i_REQ  input  2  per-requester access request; bit n belongs to requester n.
REQ-006 i_WE  input  2  per-requester op: 1 = write RAM, 0 = read RAM.
REQ-007 i_ADDR0, i_ADDR1  input  ADDR_WIDTH each  requester 0/1 address.
REQ-008 i_WDATA0, i_WDATA1  input  DATA_WIDTH each  requester 0/1 write data.
REQ-009 i_BUS  input  DATA_WIDTH  resolved value of the shared bus.
REQ-010 o_GRANT  output  2  one-hot owner of the current transaction; 0 when idle.
REQ-011 o_ACK  output  2  one-cycle completion pulse to the granted requester.
REQ-012 o_RDATA  output  DATA_WIDTH  read data; valid in the o_ACK cycle, held until the next read.
REQ-013 o_BUSY  output  1  high in every state except IDLE.
REQ-014 o_MAR_DATA  output  ADDR_WIDTH  address to the RAM.
REQ-015 o_RAM_READ_BUS  output  1  RAM captures bus on the next edge (memory write).
REQ-016 o_RAM_WRITE_BUS  output  1  RAM drives the bus (memory read).
REQ-017 o_BUS_DRIVE, o_BUS_DATA  output  1, DATA_WIDTH  tri-state enable and data; the top level builds the driver.

Function
REQ-018 SHALL implement a four-state FSM: IDLE -> ADDR -> XFER -> DONE -> IDLE; all outputs registered.
REQ-019 IDLE: if any i_REQ is high, choose the winner, latch its op, address and write data, set o_GRANT, and go to ADDR; otherwise stay.
REQ-020 ADDR: o_MAR_DATA = latched address; no strobes asserted.
REQ-021 XFER, write: o_RAM_READ_BUS=1, o_BUS_DRIVE=1, o_BUS_DATA = latched data for exactly one cycle.
REQ-022 XFER, read: o_RAM_WRITE_BUS=1 for exactly one cycle; i_BUS is sampled into o_RDATA at the closing edge.
REQ-023 DONE: o_ACK[owner]=1 for one cycle, strobes low; at the next edge clear o_GRANT and return to IDLE.
REQ-024 Latency: request first sampled high at edge N gives ADDR in cycle N+1, XFER in N+2, ack in N+3, with the next grant no earlier than edge N+4.
REQ-025 o_MAR_DATA SHALL hold its value from ADDR through DONE and otherwise keep its last value.
REQ-026 Arbitration: a single request wins outright; simultaneous requests go round-robin to the requester not granted last.
REQ-027 The last-granted pointer SHALL update only when a grant is issued.
REQ-028 A requester SHALL hold i_REQ until its ack; if i_REQ drops mid-transaction, the transaction still completes and acks.
REQ-029 A request still high in the IDLE cycle after its ack SHALL be treated as a new transaction.
REQ-030 o_BUS_DRIVE and o_RAM_WRITE_BUS SHALL never be high in the same cycle (no bus contention).
REQ-031 o_RAM_READ_BUS and o_RAM_WRITE_BUS SHALL never both be high.
REQ-032 Input changes outside IDLE SHALL NOT affect the transaction in flight.

Reset
REQ-033 While i_RESET_N=0: state IDLE; o_GRANT, o_ACK, o_BUSY, o_RAM_READ_BUS, o_RAM_WRITE_BUS and o_BUS_DRIVE are 0, asserted immediately and without a clock edge.
REQ-034 While i_RESET_N=0: o_MAR_DATA, o_RDATA and o_BUS_DATA are 0, and the last-granted pointer is 1, so requester 0 wins the first tie.
REQ-035 Reset asserted mid-transaction SHALL abort it with no ack; the aborted requester must re-request after reset.

Verification
REQ-036 Req0 write, addr 0x10, data 0xA5 -> RAM strobe in XFER, ack0 at N+3; a later req0 read of 0x10 returns o_RDATA=0xA5.
REQ-037 i_REQ=2'b11 held continuously after reset -> grants alternate 0,1,0,1 with an ack every 4 cycles.
REQ-038 Req1 read of a RAM preloaded 0x3C at 0xFF -> o_MAR_DATA=0xFF, o_RAM_WRITE_BUS one cycle, o_RDATA=0x3C with ack1.
REQ-039 Req0 dropped during ADDR -> transaction completes, ack0 pulses, FSM returns to IDLE and issues no second grant.
REQ-040 i_RESET_N low during XFER of a write -> all strobes 0 immediately, no ack; after release, req1 then req0 tie -> requester 0 granted first.
REQ-041 Every test: assert o_BUS_DRIVE and o_RAM_WRITE_BUS are never both high, and o_ACK is never set outside DONE.
